// File: rtl/hilo_ctrl.sv
// HI/LO register controller: sequences multiply and divide operations,
// captures their results into HI/LO, and provides direct mthi/mtlo writes.
// A bounded wait counter aborts an operation whose result never arrives.
module hilo_ctrl #(
    parameter int TIMEOUT = 40
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        mult_req,
    input  logic        div_req,
    output logic        mult_start,
    input  logic        mult_done,
    input  logic [31:0] mult_hi,
    input  logic [31:0] mult_lo,
    output logic        div_start,
    input  logic        div_done,
    input  logic [31:0] div_hi,
    input  logic [31:0] div_lo,
    input  logic        div_zero,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        busy,
    output logic        divz,
    output logic        timeout_err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] MWAIT = 2'd1;
    localparam logic [1:0] DWAIT = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [31:0]   hi;
    logic [31:0]   lo;
    logic          expired;

    // Wait budget exhausted once the counter has saturated at TIMEOUT.
    assign expired = (cnt == CW'(TIMEOUT));

    // HI/LO are presented straight from their registers; busy is any wait state.
    always_comb begin
        hi_out = hi;
        lo_out = lo;
        busy   = (state != IDLE);
    end

    // Operation sequencing, result capture, direct writes and error flags.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state       <= IDLE;
            cnt         <= '0;
            hi          <= '0;
            lo          <= '0;
            mult_start  <= 1'b0;
            div_start   <= 1'b0;
            divz        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            mult_start <= 1'b0;
            div_start  <= 1'b0;
            divz       <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    // Direct writes land even when an operation starts this cycle;
                    // the operation's result overwrites them later.
                    if (mthi) hi <= wdata;
                    if (mtlo) lo <= wdata;
                    if (mult_req) begin
                        state      <= MWAIT;
                        mult_start <= 1'b1;
                    end else if (div_req) begin
                        state     <= DWAIT;
                        div_start <= 1'b1;
                    end
                end
                MWAIT: begin
                    // A done seen alongside the start pulse is left over from the
                    // previous operation and must not be taken as this result.
                    if (mult_done && !mult_start) begin
                        hi    <= mult_hi;
                        lo    <= mult_lo;
                        state <= IDLE;
                    end else if (expired) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DWAIT: begin
                    if (div_done && !div_start) begin
                        if (div_zero) begin
                            divz <= 1'b1;
                        end else begin
                            hi <= div_hi;
                            lo <= div_lo;
                        end
                        state <= IDLE;
                    end else if (expired) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_ctrl.sv
// Directed bench for hilo_ctrl: mult/div sequencing, stale done, divide by
// zero, timeout, direct writes, and reset during an outstanding operation.
module tb_hilo_ctrl;

    logic        clk = 1'b0;
    logic        Reset;
    logic        mult_req, div_req;
    logic        mult_start, div_start;
    logic        mult_done, div_done, div_zero;
    logic [31:0] mult_hi, mult_lo, div_hi, div_lo;
    logic        mthi, mtlo;
    logic [31:0] wdata;
    logic [31:0] hi_out, lo_out;
    logic        busy, divz, timeout_err;

    int total = 0;
    int bad   = 0;

    hilo_ctrl #(.TIMEOUT(40)) dut (
        .clk(clk), .Reset(Reset),
        .mult_req(mult_req), .div_req(div_req),
        .mult_start(mult_start), .mult_done(mult_done),
        .mult_hi(mult_hi), .mult_lo(mult_lo),
        .div_start(div_start), .div_done(div_done),
        .div_hi(div_hi), .div_lo(div_lo), .div_zero(div_zero),
        .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
        .hi_out(hi_out), .lo_out(lo_out),
        .busy(busy), .divz(divz), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        Reset = 1'b1; mult_req = 0; div_req = 0; mult_done = 0; div_done = 0;
        div_zero = 0; mult_hi = 0; mult_lo = 0; div_hi = 0; div_lo = 0;
        mthi = 0; mtlo = 0; wdata = 0;
        // Drive garbage alongside reset: reset must win.
        mthi = 1; wdata = 32'h5555AAAA; mult_req = 1;
        step(); step();
        chk("rst_hi", hi_out, 32'h0);
        chk("rst_lo", lo_out, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_mstart", {31'b0, mult_start}, 32'h0);
        chk("rst_dstart", {31'b0, div_start}, 32'h0);
        chk("rst_divz", {31'b0, divz}, 32'h0);
        chk("rst_tmo", {31'b0, timeout_err}, 32'h0);
        Reset = 0; mthi = 0; mult_req = 0; wdata = 0;

        // Direct writes in IDLE.
        mthi = 1; wdata = 32'h12345678; step(); mthi = 0;
        chk("mthi_idle", hi_out, 32'h12345678);
        chk("mthi_lo_kept", lo_out, 32'h0);
        mtlo = 1; wdata = 32'hAABBCCDD; step(); mtlo = 0;
        chk("mtlo_idle", lo_out, 32'hAABBCCDD);
        mthi = 1; mtlo = 1; wdata = 32'h11112222; step(); mthi = 0; mtlo = 0;
        chk("mthilo_hi", hi_out, 32'h11112222);
        chk("mthilo_lo", lo_out, 32'h11112222);

        // Multiply with result 33 cycles after the request edge.
        mult_hi = 32'hFFFFFFFF; mult_lo = 32'hFFFFFFEB;
        mult_req = 1; step(); mult_req = 0;
        chk("m_start", {31'b0, mult_start}, 32'h1);
        chk("m_busy", {31'b0, busy}, 32'h1);
        mthi = 1; wdata = 32'hDEADBEEF; div_req = 1; step(); mthi = 0; div_req = 0;
        chk("m_start_1cyc", {31'b0, mult_start}, 32'h0);
        chk("mthi_busy", hi_out, 32'h11112222);
        chk("dreq_busy", {31'b0, div_start}, 32'h0);
        repeat (30) step();
        chk("m_busy_wait", {31'b0, busy}, 32'h1);
        chk("m_hi_wait", hi_out, 32'h11112222);
        mult_done = 1; step(); mult_done = 0;
        chk("m_done_busy", {31'b0, busy}, 32'h0);
        chk("m_done_hi", hi_out, 32'hFFFFFFFF);
        chk("m_done_lo", lo_out, 32'hFFFFFFEB);

        // Stale done held through the start cycle.
        mult_done = 1; mult_hi = 32'h0BAD0BAD; mult_lo = 32'h0BAD0BAD;
        mult_req = 1; step(); mult_req = 0;
        chk("s_start", {31'b0, mult_start}, 32'h1);
        step(); mult_done = 0;
        chk("s_busy", {31'b0, busy}, 32'h1);
        chk("s_hi_kept", hi_out, 32'hFFFFFFFF);
        mult_hi = 32'h00001234; mult_lo = 32'h00005678;
        repeat (3) step();
        mult_done = 1; step(); mult_done = 0;
        chk("s_busy_done", {31'b0, busy}, 32'h0);
        chk("s_hi", hi_out, 32'h00001234);
        chk("s_lo", lo_out, 32'h00005678);

        // Done in IDLE ignored.
        mult_done = 1; div_done = 1; mult_hi = 32'h77777777; div_hi = 32'h66666666;
        step(); mult_done = 0; div_done = 0;
        chk("idle_done_hi", hi_out, 32'h00001234);
        chk("idle_done_busy", {31'b0, busy}, 32'h0);

        // Divide by zero.
        div_req = 1; step(); div_req = 0;
        chk("dz_start", {31'b0, div_start}, 32'h1);
        div_done = 1; div_zero = 1; div_hi = 32'd5; div_lo = 32'd9;
        step();
        chk("dz_stale_busy", {31'b0, busy}, 32'h1);
        step(); div_done = 0; div_zero = 0;
        chk("dz_divz", {31'b0, divz}, 32'h1);
        chk("dz_busy", {31'b0, busy}, 32'h0);
        chk("dz_hi", hi_out, 32'h00001234);
        chk("dz_lo", lo_out, 32'h00005678);
        step();
        chk("dz_divz_1cyc", {31'b0, divz}, 32'h0);

        // Normal divide, with mult_done from the other unit ignored.
        div_req = 1; step(); div_req = 0;
        step();
        mult_done = 1; step(); mult_done = 0;
        chk("d_other_done", {31'b0, busy}, 32'h1);
        div_done = 1; step(); div_done = 0;
        chk("d_hi", hi_out, 32'd5);
        chk("d_lo", lo_out, 32'd9);
        chk("d_divz", {31'b0, divz}, 32'h0);

        // Both requests: multiply wins.
        mult_req = 1; div_req = 1; step(); mult_req = 0; div_req = 0;
        chk("both_mstart", {31'b0, mult_start}, 32'h1);
        chk("both_dstart", {31'b0, div_start}, 32'h0);
        mult_hi = 32'h0000000A; mult_lo = 32'h0000000B;
        step(); mult_done = 1; step(); mult_done = 0;
        chk("both_lo", lo_out, 32'h0000000B);

        // Write plus multiply in the same cycle, then timeout.
        mthi = 1; wdata = 32'hCAFEF00D; mult_req = 1; step(); mthi = 0; mult_req = 0;
        chk("wm_hi", hi_out, 32'hCAFEF00D);
        chk("wm_start", {31'b0, mult_start}, 32'h1);
        repeat (40) step();
        chk("t_busy_last", {31'b0, busy}, 32'h1);
        chk("t_err_early", {31'b0, timeout_err}, 32'h0);
        step();
        chk("t_busy", {31'b0, busy}, 32'h0);
        chk("t_err", {31'b0, timeout_err}, 32'h1);
        chk("t_hi", hi_out, 32'hCAFEF00D);
        chk("t_lo", lo_out, 32'h0000000B);
        repeat (5) step();
        chk("t_sticky", {31'b0, timeout_err}, 32'h1);

        // Reset during MWAIT, then late done.
        mult_hi = 32'h99999999; mult_lo = 32'h88888888;
        mult_req = 1; step(); mult_req = 0;
        repeat (10) step();
        Reset = 1; step(); Reset = 0;
        chk("r_hi", hi_out, 32'h0);
        chk("r_lo", lo_out, 32'h0);
        chk("r_busy", {31'b0, busy}, 32'h0);
        chk("r_tmo", {31'b0, timeout_err}, 32'h0);
        mult_done = 1; step(); step(); mult_done = 0;
        chk("r_late_hi", hi_out, 32'h0);
        chk("r_late_lo", lo_out, 32'h0);
        chk("r_late_busy", {31'b0, busy}, 32'h0);
        chk("r_late_mstart", {31'b0, mult_start}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hilo_ctrl.md
HILO_CTRL -- requirements
Module: hilo_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 40, giving the maximum wait cycles for a mult/div result before abort.
REQ-002 clk  input  1  clock; all state changes on the rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 mult_req  input  1  control request to start a multiply (sampled each edge).
REQ-005 div_req  input  1  control request to start a divide.
REQ-006 mult_start  output  1  one-cycle start pulse to the multiplier's multControl.
REQ-007 mult_done  input  1  multiplier result-valid level (multStop).
REQ-008 mult_hi, mult_lo  input  32 each  multiplier result words.
REQ-009 div_start  output  1  one-cycle start pulse to the divider.
REQ-010 div_done  input  1  divider result-valid level.
REQ-011 div_hi, div_lo  input  32 each  divider remainder / quotient.
REQ-012 div_zero  input  1  divider divide-by-zero flag, valid with div_done.
REQ-013 mthi, mtlo  input  1 each  direct write strobes for HI / LO.
REQ-014 wdata  input  32  data for mthi/mtlo.
REQ-015 hi_out, lo_out  output  32 each  current HI / LO register contents.
REQ-016 busy  output  1  high while a mult/div is outstanding (stall to control).
REQ-017 divz  output  1  one-cycle pulse on a divide-by-zero completion.
REQ-018 timeout_err  output  1  sticky flag set when a wait exceeds TIMEOUT.

Function
REQ-019 The block SHALL implement FSM states IDLE, MWAIT, DWAIT, with hi_out/lo_out driven directly from HI/LO registers.
REQ-020 IDLE with mult_req=1 at edge N SHALL give state MWAIT, busy=1 and mult_start=1 for cycle N+1 only, with wait counter cleared to 0.
REQ-021 IDLE with div_req=1 and mult_req=0 SHALL behave as REQ-020 using DWAIT/div_start.
REQ-022 mult_req and div_req both high in IDLE: multiply SHALL start, div_req SHALL be ignored.
REQ-023 mult_req/div_req while busy=1 SHALL be ignored (no queueing).
REQ-024 In MWAIT/DWAIT the wait counter SHALL increment by 1 per cycle, saturating at TIMEOUT.
REQ-025 mult_done/div_done SHALL be ignored in the cycle mult_start/div_start is high (stale done from previous operation).
REQ-026 MWAIT with mult_done=1 (after REQ-025 cycle) SHALL, at that edge, load HI<=mult_hi, LO<=mult_lo, return to IDLE, drop busy; new values visible on the next cycle.
REQ-027 DWAIT with div_done=1 and div_zero=0 SHALL load HI<=div_hi, LO<=div_lo, return to IDLE, drop busy.
REQ-028 DWAIT with div_done=1 and div_zero=1 SHALL leave HI/LO unchanged, pulse divz for one cycle, return to IDLE.
REQ-029 Counter reaching TIMEOUT without done SHALL set timeout_err=1, leave HI/LO unchanged, return to IDLE, drop busy.
REQ-030 timeout_err SHALL remain 1 until Reset.
REQ-031 mult_done/div_done in IDLE, or of the non-selected unit, SHALL be ignored.
REQ-032 mthi/mtlo in IDLE SHALL write wdata to HI/LO at that edge; both high writes both.
REQ-033 mthi/mtlo while busy=1 SHALL be ignored.
REQ-034 mthi/mtlo with mult_req in the same IDLE cycle: the write SHALL occur and the multiply SHALL start; its result later overwrites HI/LO.

Reset
REQ-035 Reset=1 at an edge SHALL force IDLE, HI=LO=0, counter=0, busy=0, mult_start=0, div_start=0, divz=0, timeout_err=0, overriding all other inputs.
REQ-036 Reset mid-MWAIT/DWAIT SHALL abort the operation; a later done from the slave SHALL be ignored per REQ-031.

Verification
REQ-037 mult_req pulse; stub returns mult_hi=32'hFFFFFFFF, mult_lo=32'hFFFFFFEB with done 33 cycles later -> mult_start exactly 1 cycle, busy high until done edge, then hi_out=FFFFFFFF, lo_out=FFFFFFEB.
REQ-038 Stub holds mult_done=1 from previous op during the mult_start cycle, real done 5 cycles later -> stale done ignored, HI/LO load only on the real done.
REQ-039 div_req; stub div_done=1, div_zero=1, div_hi=5, div_lo=9 -> HI/LO unchanged, divz one-cycle pulse, busy drops.
REQ-040 mult_req, stub never asserts done, TIMEOUT=40 -> after 40 wait cycles timeout_err=1 (sticky), busy=0, HI/LO unchanged.
REQ-041 mthi with wdata=32'h12345678 while busy -> HI unchanged; same in IDLE -> hi_out=12345678 next cycle.
REQ-042 Reset asserted 10 cycles into MWAIT, then stub done -> all outputs zero, HI/LO stay 0, state IDLE.
